// File: rtl/os_sequencer_pkg.sv
// Shared definitions for the output-stationary sequencer: the bit layout of
// the core instruction word, the idle instruction and the FSM state type.
package os_sequencer_pkg;

    localparam int INST_W = 40;
    localparam int AX_W   = 8;   // xmem address width
    localparam int AP_W   = 9;   // pmem address width
    localparam int CNT_W  = 16;  // shared phase counter width

    localparam int B_BYPASS   = 39;
    localparam int B_ACC      = 38;
    localparam int B_CEN_P    = 37;
    localparam int B_WEN_P    = 36;
    localparam int B_AP_LO    = 27;
    localparam int B_CEN1     = 26;
    localparam int B_A1_LO    = 18;
    localparam int B_CEN0     = 17;
    localparam int B_WEN0     = 16;
    localparam int B_A0_LO    = 8;
    localparam int B_OFIFO_RD = 7;
    localparam int B_IFIFO_WR = 6;
    localparam int B_IFIFO_RD = 5;
    localparam int B_L0_RD    = 4;
    localparam int B_L0_WR    = 3;
    localparam int B_MODE     = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // All memories deselected, no strobes, no compute.
    localparam logic [INST_W-1:0] OS_IDLE_INST = 40'h30_0403_0000;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        READ,
        TAIL,
        DONE
    } os_state_t;

endpackage

// File: rtl/os_sequencer_if.sv
// Control/handshake bundle between the top-level controller and the sequencer.
interface os_sequencer_if;
    import os_sequencer_pkg::*;

    logic              start;
    logic              l0_ready;
    logic              ififo_ready;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;

    modport master (
        output start, l0_ready, ififo_ready, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, l0_ready, ififo_ready, ofifo_valid,
        output inst, busy, done
    );
endinterface

// File: rtl/os_sequencer_strobe_pipe.sv
// Two-stage delay turning an issued xmem beat into the FIFO write strobe
// (xmem read latency) and, one cycle later, the matching FIFO read strobe.
module os_strobe_pipe (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_issue,
    output logic o_wr,
    output logic o_rd
);
    logic r_wr;
    logic r_rd;

    // Shift the issue pulse through the wr and rd stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= 1'b0;
            r_rd <= 1'b0;
        end else begin
            r_wr <= i_issue;
            r_rd <= r_wr;
        end
    end

    assign o_wr = r_wr;
    assign o_rd = r_rd;
endmodule

// File: rtl/os_sequencer.sv
// Output-stationary tile sequencer: feeds activation/weight beats, lets the
// strobe pipe settle, shifts psums out of the PEs, drains the OFIFO into pmem
// and pulses done.
//
//  state | meaning
//  IDLE  | idle word on inst, waiting for start
//  FEED  | issue len_nij xmem beats while executing, honouring L0/IFIFO ready
//  FLUSH | two cycles with no new beats so the strobe pipe empties
//  DRAIN | drain_cycles cycles of PE shift-out (load=1, mode=1)
//  READ  | read col OFIFO rows, each written to pmem on the following cycle
//  TAIL  | issue the last pending pmem write
//  DONE  | pulse done, then return to IDLE
module os_sequencer
    import os_sequencer_pkg::*;
#(
    parameter logic [CNT_W-1:0] LEN_NIJ      = 16'd9,
    parameter logic [CNT_W-1:0] DRAIN_CYCLES = 16'd16,
    parameter logic [CNT_W-1:0] COL          = 16'd8,
    parameter logic [AX_W-1:0]  A_BASE       = 8'h00,
    parameter logic [AX_W-1:0]  W_BASE       = 8'h80,
    parameter logic [AP_W-1:0]  P_BASE       = 9'h000
) (
    input  logic           clk,
    input  logic           reset,
    os_sequencer_if.slave  bus
);
    os_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_issue;
    logic              r_wr_pend;
    logic [AP_W-1:0]   r_wr_addr;
    logic [INST_W-1:7] r_hi;
    logic [2:0]        r_lo;
    logic              r_busy;
    logic              r_done;

    logic w_l0_wr;
    logic w_l0_rd;
    logic w_if_wr;
    logic w_if_rd;

    // Sequencer FSM; every inst field except the FIFO strobes is registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_issue   <= 1'b0;
            r_wr_pend <= 1'b0;
            r_wr_addr <= '0;
            r_hi      <= OS_IDLE_INST[INST_W-1:7];
            r_lo      <= 3'b000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_hi      <= OS_IDLE_INST[INST_W-1:7];
            r_lo      <= 3'b000;
            r_issue   <= 1'b0;
            r_done    <= 1'b0;
            r_wr_pend <= 1'b0;

            // A row read on the previous cycle is written to pmem now.
            if (r_wr_pend) begin
                r_hi[B_BYPASS]           <= 1'b1;
                r_hi[B_CEN_P]            <= 1'b0;
                r_hi[B_WEN_P]            <= 1'b0;
                r_hi[B_AP_LO +: AP_W]    <= r_wr_addr;
            end

            case (r_state)
                IDLE: begin
                    // busy stays high through the done cycle, so a start
                    // arriving then is dropped.
                    if (bus.start && !r_busy) begin
                        r_state <= FEED;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                FEED: begin
                    r_lo <= 3'b110;
                    if (bus.l0_ready && bus.ififo_ready) begin
                        r_hi[B_CEN0]          <= 1'b0;
                        r_hi[B_CEN1]          <= 1'b0;
                        r_hi[B_A0_LO +: AX_W] <= A_BASE + r_cnt[AX_W-1:0];
                        r_hi[B_A1_LO +: AX_W] <= W_BASE + r_cnt[AX_W-1:0];
                        r_issue               <= 1'b1;
                        if (r_cnt == LEN_NIJ - 16'd1) begin
                            r_state <= FLUSH;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + 16'd1;
                        end
                    end
                end
                FLUSH: begin
                    r_lo <= 3'b100;
                    if (r_cnt == 16'd1) begin
                        r_state <= DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    r_lo <= 3'b101;
                    if (r_cnt == DRAIN_CYCLES - 16'd1) begin
                        r_state <= READ;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                READ: begin
                    if (bus.ofifo_valid) begin
                        r_hi[B_OFIFO_RD] <= 1'b1;
                        r_wr_pend        <= 1'b1;
                        r_wr_addr        <= P_BASE + r_cnt[AP_W-1:0];
                        if (r_cnt == COL - 16'd1) begin
                            r_state <= TAIL;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + 16'd1;
                        end
                    end
                end
                TAIL: begin
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    os_strobe_pipe u_l0_pipe (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_issue (r_issue),
        .o_wr    (w_l0_wr),
        .o_rd    (w_l0_rd)
    );

    os_strobe_pipe u_ififo_pipe (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_issue (r_issue),
        .o_wr    (w_if_wr),
        .o_rd    (w_if_rd)
    );

    assign bus.inst = {r_hi, w_if_wr, w_if_rd, w_l0_rd, w_l0_wr, r_lo};
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: doc/os_sequencer.md
# os_sequencer

Output-stationary sequencer that generates the 40-bit `inst` word for `core`, replacing hand-driven testbench stimulus. On `start` it does four things in order:
- streams `len_nij` activation/weight pairs from xmem into L0 and IFIFO while the array executes;
- shifts the accumulated psums out of the PEs;
- drains `col` OFIFO entries into pmem;
- pulses `done`.

It sits between the top-level control and `core.inst`, and obeys `l0_ready`, `ififo_ready` and `ofifo_valid` backpressure.

## Interface
- `len_nij`, 9: activation/weight beats per tile.
- `drain_cycles`, 16: cycles of PE shift-out (load=1, mode=1).
- `col`, 8: OFIFO entries read per tile.
- `a_base`, 8'h00: first activation xmem address (A0).
- `w_base`, 8'h80: first weight xmem address (A1).
- `p_base`, 9'h000: first pmem write address.
- `clk` in 1: clock, all flops rising-edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle request; ignored unless `busy`=0.
- `l0_ready` in 1: L0 can accept a beat.
- `ififo_ready` in 1: IFIFO can accept a beat.
- `ofifo_valid` in 1: OFIFO holds a full row.
- `inst` out 40: core instruction, registered. Field layout:
  - [39] psum_bypass, [38] acc
  - [37] CEN_pmem, [36] WEN_pmem, [35:27] A_pmem
  - [26] CEN1_xmem, [25:18] A1_xmem
  - [17] CEN0_xmem, [16] WEN0_xmem, [15:8] A0_xmem
  - [7] ofifo_rd, [6] ififo_wr, [5] ififo_rd, [4] l0_rd, [3] l0_wr
  - [2] mode, [1] execute, [0] load
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at tile completion.

## Operation
- Idle word: CEN_pmem, WEN_pmem, CEN1_xmem, CEN0_xmem and WEN0_xmem all =1; every other bit =0. Value is 40'h30_0403_0000.
- States and transitions:
  - IDLE → FEED on `start`.
  - FEED → FLUSH after `len_nij` issued beats.
  - FLUSH: 2 cycles → DRAIN.
  - DRAIN: `drain_cycles` cycles → READ.
  - READ → TAIL after `col` reads.
  - TAIL: 1 cycle → DONE.
  - DONE: 1 cycle → IDLE.
- FEED issue rule: a beat issues in a cycle with `l0_ready & ififo_ready`. Beat k drives:
  - CEN0=0, WEN0=1, A0=a_base+k
  - CEN1=0, A1=w_base+k
  - mode=1, execute=1
- FEED stall: otherwise CEN0=CEN1=1, mode/execute held at 1, and k holds.
- FIFO strobes (2-stage pipe, running in every state):
  - l0_wr and ififo_wr assert 1 cycle after each issued beat (xmem read latency).
  - l0_rd and ififo_rd assert 1 cycle after the corresponding wr.
- FLUSH: no new beats; mode=1, execute=0, load=0. Exists only so the strobe pipe empties.
- DRAIN: mode=1, load=1, execute=0, xmem disabled.
- READ, per cycle with `ofifo_valid`=1:
  - ofifo_rd=1 and read count r increments.
  - The next cycle drives CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+r_prev, psum_bypass=1.
  - If `ofifo_valid`=0, ofifo_rd=0 and r holds.
- TAIL: issues the final pmem write.
- Address arithmetic: A0/A1 are 8-bit, A_pmem is 9-bit, all modulo (wrap silently).
- acc is always 0.

## Timing
- Reset (`reset`=0, async): state=IDLE, counters=0, strobe pipe cleared, `inst`=idle word, `busy`=0, `done`=0.
  - Reset mid-tile aborts immediately. No partial pmem write completes after the reset edge.
- Start: `start` sampled at edge 0; the first FEED beat can appear on `inst` after edge 1. `busy` rises after edge 0.
- Best case for defaults (all ready/valid high):
  - FEED cycles 1–9, FLUSH 10–11, DRAIN 12–27
  - ofifo_rd cycles 28–35, pmem writes 29–36
  - `done` at cycle 37, `busy` low from 38
- Simultaneous events:
  - `start` during DONE is ignored.
  - Ready dropping on the same edge as the last beat: the beat counts only if ready was sampled high.
- `ofifo_valid` low indefinitely in READ: wait forever. No timeout.

## Structure
- Package `os_sequencer_pkg` holds:
  - inst bit-position/width localparams
  - `OS_IDLE_INST` constant
  - `os_state_t` enum: IDLE, FEED, FLUSH, DRAIN, READ, TAIL, DONE
- Sub-module `os_strobe_pipe` is the 2-stage delay producing wr/rd strobes from the issue pulse; it is reused for the L0 and IFIFO lanes.

## Test plan
- Reset/idle: hold `reset`=0, release, no `start` → `inst`=40'h30_0403_0000, `busy`=0 for 20 cycles.
- Full-rate tile: ready/valid tied high, `start` at cycle 0:
  - A0 sequence 0..8 and A1 sequence 0x80..0x88 on cycles 1–9
  - l0_wr on cycles 2–10, l0_rd on cycles 3–11
  - A_pmem 0..7 on cycles 29–36, `done` at 37
- Backpressure: `l0_ready`=0 on cycles 3–5 → beats at cycles 1, 2, 6–12, still 9 beats, addresses contiguous, `done` at 40.
- OFIFO gap: `ofifo_valid`=0 for 4 cycles after the 3rd read → exactly 8 ofifo_rd pulses and 8 pmem writes at A_pmem 0..7 without holes, `done` 4 cycles later than the 37-cycle baseline.
- Abort: `reset`=0 at cycle 15 (DRAIN), then restart → idle word immediately; the second tile replays the full-rate trace exactly.
- Wrap: `w_base`=8'hFE → A1 sequence FE, FF, 00..06.
